// File: rtl/block_dispatcher.sv
// Block-grid dispatcher: walks a raster block grid and feeds offsets to the tile
// accumulation unit under a credit limit. Optional stall counter: BLOCK_DISPATCHER_PERF_EN.
module block_dispatcher #(
   parameter int VDIM         = 4,
   parameter int WBW          = 16,
   parameter int MAX_INFLIGHT = 2,
   parameter int IF_BW        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_cfg_rdy,
   output logic                       o_cfg_ack,
   input  logic [VDIM-1:0][WBW-1:0]   i_bgrid_step,
   input  logic [VDIM-1:0][WBW-1:0]   i_bgrid_end,
   output logic                       o_bofs_rdy,
   input  logic                       i_bofs_ack,
   output logic [VDIM-1:0][WBW-1:0]   o_bofs,
   input  logic                       i_blkdone_dval,
   output logic                       o_done_dval,
   output logic                       o_busy
`ifdef BLOCK_DISPATCHER_PERF_EN
   ,
   output logic [31:0]                o_stall_cycles
`endif
);

   // Handshake: a transfer happens on any cycle with rdy && ack; once rdy is
   // raised, the offset is held stable and rdy stays high until that transfer.
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DISPATCH = 2'd1;
   localparam logic [1:0] S_DRAIN    = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [IF_BW-1:0] C_MAX = IF_BW'(MAX_INFLIGHT);

   logic [1:0]                r_state;
   logic [VDIM-1:0][WBW-1:0]  r_step;
   logic [VDIM-1:0][WBW-1:0]  r_end;
   logic [VDIM-1:0][WBW-1:0]  r_bofs;
   logic [IF_BW-1:0]          r_inflight;

   logic                      w_cfg_xfer;
   logic                      w_bofs_rdy;
   logic                      w_bofs_xfer;
   logic                      w_retire;
   logic                      w_empty;
   logic                      w_last;
   logic [VDIM:0]             w_carry;
   logic [VDIM-1:0][WBW:0]    w_sum;
   logic [VDIM-1:0]           w_wrap;
   logic [VDIM-1:0][WBW-1:0]  w_nxt_bofs;

   assign w_cfg_xfer  = i_cfg_rdy && (r_state == S_IDLE);
   assign w_bofs_rdy  = (r_state == S_DISPATCH) && (r_inflight < C_MAX);
   assign w_bofs_xfer = w_bofs_rdy && i_bofs_ack;
   // Retire pulses outside an active job, or with nothing outstanding, are dropped.
   assign w_retire    = i_blkdone_dval && (r_inflight != '0) &&
                        ((r_state == S_DISPATCH) || (r_state == S_DRAIN));

   always_comb begin
      w_empty = 1'b0;
      for (int d = 0; d < VDIM; d++) begin
         if (i_bgrid_end[d] == '0) w_empty = 1'b1;
      end
   end

   // Raster advance, last dimension fastest; the sum is one bit wider so it never wraps.
   always_comb begin
      w_carry       = '0;
      w_sum         = '0;
      w_wrap        = '0;
      w_nxt_bofs    = r_bofs;
      w_carry[VDIM] = 1'b1;
      for (int d = VDIM - 1; d >= 0; d--) begin
         w_sum[d]   = {1'b0, r_bofs[d]} + {1'b0, r_step[d]};
         w_wrap[d]  = (w_sum[d] >= {1'b0, r_end[d]}) || (r_step[d] == '0);
         w_carry[d] = w_carry[d+1] && w_wrap[d];
         if (w_carry[d+1]) begin
            w_nxt_bofs[d] = w_wrap[d] ? '0 : w_sum[d][WBW-1:0];
         end
      end
   end

   assign w_last = w_carry[0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_step     <= '0;
         r_end      <= '0;
         r_bofs     <= '0;
         r_inflight <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cfg_xfer) begin
                  r_step  <= i_bgrid_step;
                  r_end   <= i_bgrid_end;
                  r_bofs  <= '0;
                  r_state <= w_empty ? S_DONE : S_DISPATCH;
               end
            end
            S_DISPATCH: begin
               if (w_bofs_xfer) begin
                  r_bofs <= w_nxt_bofs;
                  if (w_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_inflight == '0) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_bofs_xfer && !w_retire) begin
            r_inflight <= r_inflight + IF_BW'(1);
         end else if (!w_bofs_xfer && w_retire) begin
            r_inflight <= r_inflight - IF_BW'(1);
         end
      end
   end

   assign o_cfg_ack   = w_cfg_xfer;
   assign o_bofs_rdy  = w_bofs_rdy;
   assign o_bofs      = r_bofs;
   assign o_done_dval = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);

`ifdef BLOCK_DISPATCHER_PERF_EN
   logic [31:0] r_stall_cycles;

   // Consumer stalls and credit stalls both count, only while dispatching.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cycles <= '0;
      end else if (w_cfg_xfer) begin
         r_stall_cycles <= '0;
      end else if ((r_state == S_DISPATCH) &&
                   ((w_bofs_rdy && !i_bofs_ack) || (r_inflight == C_MAX)) &&
                   (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher; covers the stall counter when
// BLOCK_DISPATCHER_PERF_EN is defined.
module tb_block_dispatcher;

   localparam int VDIM = 4;
   localparam int WBW  = 16;
   localparam int W    = VDIM * WBW;

   logic                     i_clk = 1'b0;
   logic                     i_rst;
   logic                     i_cfg_rdy;
   logic                     o_cfg_ack;
   logic [VDIM-1:0][WBW-1:0] i_bgrid_step;
   logic [VDIM-1:0][WBW-1:0] i_bgrid_end;
   logic                     o_bofs_rdy;
   logic                     i_bofs_ack;
   logic [VDIM-1:0][WBW-1:0] o_bofs;
   logic                     i_blkdone_dval;
   logic                     o_done_dval;
   logic                     o_busy;
`ifdef BLOCK_DISPATCHER_PERF_EN
   logic [31:0]              o_stall_cycles;
`endif

   logic       ack_en    = 1'b0;
   logic       auto_en   = 1'b0;
   logic       man_bd    = 1'b0;
   logic       auto_bd   = 1'b0;
   logic [1:0] bd_pipe   = 2'b00;
   logic       last_xfer = 1'b0;
   logic       prev_hold = 1'b0;
   logic [W-1:0] prev_bofs = '0;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cfg_cyc = 0;

   // The consumer only acks while an offset is offered.
   assign i_bofs_ack     = ack_en && o_bofs_rdy;
   assign i_blkdone_dval = auto_bd | man_bd;

   block_dispatcher #(.VDIM(VDIM), .WBW(WBW), .MAX_INFLIGHT(2)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_cfg_rdy      (i_cfg_rdy),
      .o_cfg_ack      (o_cfg_ack),
      .i_bgrid_step   (i_bgrid_step),
      .i_bgrid_end    (i_bgrid_end),
      .o_bofs_rdy     (o_bofs_rdy),
      .i_bofs_ack     (i_bofs_ack),
      .o_bofs         (o_bofs),
      .i_blkdone_dval (i_blkdone_dval),
      .o_done_dval    (o_done_dval),
      .o_busy         (o_busy)
`ifdef BLOCK_DISPATCHER_PERF_EN
      ,
      .o_stall_cycles (o_stall_cycles)
`endif
   );

   // Clock and cycle count
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
      logic [VDIM-1:0][WBW-1:0] t;
      t[0] = a0[WBW-1:0];
      t[1] = a1[WBW-1:0];
      t[2] = a2[WBW-1:0];
      t[3] = a3[WBW-1:0];
      return t;
   endfunction

   // Offsets along one dimension: 0, s, 2s, ... below e; a zero step yields only 0.
   function automatic int adv(input int v, input int s, input int e);
      return (s == 0) ? e : v + s;
   endfunction

   task automatic push_model(input logic [VDIM-1:0][WBW-1:0] e, input logic [VDIM-1:0][WBW-1:0] s);
      for (int a = 0; a < int'(e[0]); a = adv(a, int'(s[0]), int'(e[0])))
         for (int b = 0; b < int'(e[1]); b = adv(b, int'(s[1]), int'(e[1])))
            for (int c = 0; c < int'(e[2]); c = adv(c, int'(s[2]), int'(e[2])))
               for (int d = 0; d < int'(e[3]); d = adv(d, int'(s[3]), int'(e[3])))
                  exp_q.push_back(pk(a, b, c, d));
   endtask

   // Monitor / scoreboard: every bofs transfer is popped and compared.
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_hold = 1'b0;
         last_xfer = 1'b0;
      end else begin
         last_xfer = o_bofs_rdy && i_bofs_ack;
         if (last_xfer) begin
            xfer_cnt++;
            chk("bofs_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) chk("bofs", o_bofs, exp_q.pop_front());
         end
         if (prev_hold) begin
            chk("hold_rdy", W'(o_bofs_rdy), W'(1));
            chk("hold_bofs", o_bofs, prev_bofs);
         end
         prev_hold = o_bofs_rdy && !i_bofs_ack;
         prev_bofs = o_bofs;
         if (o_done_dval) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Retire model: blkdone two cycles after each transfer when enabled.
   always @(posedge i_clk) begin
      #1;
      bd_pipe = {bd_pipe[0], last_xfer && auto_en};
      auto_bd = bd_pipe[1];
   end

   // Driver tasks
   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_cfg(input int e0, input int e1, input int e2, input int e3,
                            input int s0, input int s1, input int s2, input int s3);
      logic ok;
      i_bgrid_end  = pk(e0, e1, e2, e3);
      i_bgrid_step = pk(s0, s1, s2, s3);
      push_model(i_bgrid_end, i_bgrid_step);
      i_cfg_rdy = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge i_clk);
         if (o_cfg_ack) begin
            ok = 1'b1;
            cfg_cyc = cyc;
         end
         next_cycle();
      end
      i_cfg_rdy = 1'b0;
      chk("cfg_accepted", W'(ok), W'(1));
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int k = 0; k < budget && done_cnt == start; k++) next_cycle();
      chk("done_seen", W'(done_cnt != start), W'(1));
   endtask

   int x0;
   int d0;

   initial begin
      i_rst        = 1'b1;
      i_cfg_rdy    = 1'b0;
      i_bgrid_end  = '0;
      i_bgrid_step = '0;
      repeat (3) next_cycle();
      @(negedge i_clk);
      chk("rst_bofs_rdy", W'(o_bofs_rdy), W'(0));
      chk("rst_busy", W'(o_busy), W'(0));
      chk("rst_done", W'(o_done_dval), W'(0));
      chk("rst_cfg_ack", W'(o_cfg_ack), W'(0));
      chk("rst_bofs", o_bofs, W'(0));
`ifdef BLOCK_DISPATCHER_PERF_EN
      chk("rst_stall", W'(o_stall_cycles), W'(0));
`endif
      next_cycle();
      i_rst = 1'b0;
      next_cycle();

      // Basic raster walk
      auto_en = 1'b1;
      ack_en  = 1'b1;
      x0 = xfer_cnt;
      d0 = done_cnt;
      start_cfg(1, 1, 4, 6, 1, 1, 2, 3);
      wait_done(100);
      @(negedge i_clk);
      chk("walk_busy_after", W'(o_busy), W'(0));
      repeat (3) next_cycle();
      chk("walk_xfers", W'(xfer_cnt - x0), W'(4));
      chk("walk_one_done", W'(done_cnt - d0), W'(1));
      chk("walk_q_empty", W'(exp_q.size()), W'(0));

      // Empty grid: straight to DONE, pulse on the cycle after the cfg transfer
      x0 = xfer_cnt;
      start_cfg(1, 0, 4, 4, 1, 1, 1, 1);
      wait_done(20);
      chk("empty_done_cycle", W'(done_cyc), W'(cfg_cyc + 1));
      chk("empty_xfers", W'(xfer_cnt - x0), W'(0));

      // Credit limit with blkdone withheld
      auto_en = 1'b0;
      x0 = xfer_cnt;
      start_cfg(1, 1, 1, 8, 1, 1, 1, 1);
      repeat (3) next_cycle();
      @(negedge i_clk);
      chk("credit_xfers", W'(xfer_cnt - x0), W'(2));
      chk("credit_rdy_low", W'(o_bofs_rdy), W'(0));
      chk("credit_bofs_held", o_bofs, pk(0, 0, 0, 2));
      man_bd = 1'b1;
      next_cycle();
      @(negedge i_clk);
      chk("credit_rdy_reraised", W'(o_bofs_rdy), W'(1));
      next_cycle();
      man_bd = 1'b0;
      @(negedge i_clk);
      chk("credit_simul_keeps", W'(o_bofs_rdy), W'(1));
      next_cycle();
      @(negedge i_clk);
      chk("credit_full_again", W'(o_bofs_rdy), W'(0));
      man_bd = 1'b1;
      wait_done(100);
      man_bd = 1'b0;
      chk("credit_total_xfers", W'(xfer_cnt - x0), W'(8));
      chk("credit_q_empty", W'(exp_q.size()), W'(0));

      // Zero step, then non-divisible end
      auto_en = 1'b1;
      x0 = xfer_cnt;
      start_cfg(1, 1, 5, 1, 1, 1, 0, 1);
      wait_done(50);
      chk("zstep_xfers", W'(xfer_cnt - x0), W'(1));
      x0 = xfer_cnt;
      start_cfg(1, 1, 5, 1, 1, 1, 2, 1);
      wait_done(50);
      chk("ndiv_xfers", W'(xfer_cnt - x0), W'(3));
      chk("ndiv_q_empty", W'(exp_q.size()), W'(0));

      // Reset in the middle of a job
      auto_en = 1'b0;
      repeat (4) next_cycle();
      start_cfg(1, 1, 1, 4, 1, 1, 1, 1);
      next_cycle();
      i_rst = 1'b1;
      next_cycle();
      i_rst = 1'b0;
      exp_q.delete();
      @(negedge i_clk);
      chk("rstmid_rdy", W'(o_bofs_rdy), W'(0));
      chk("rstmid_busy", W'(o_busy), W'(0));
      chk("rstmid_bofs", o_bofs, W'(0));
      next_cycle();
      man_bd = 1'b1;
      next_cycle();
      man_bd = 1'b0;
      next_cycle();
      auto_en = 1'b1;
      x0 = xfer_cnt;
      start_cfg(1, 1, 1, 3, 1, 1, 1, 1);
      wait_done(50);
      chk("rstmid_fresh_xfers", W'(xfer_cnt - x0), W'(3));
      chk("rstmid_q_empty", W'(exp_q.size()), W'(0));

`ifdef BLOCK_DISPATCHER_PERF_EN
      // Consumer holds off the first offset for three cycles
      ack_en = 1'b0;
      start_cfg(1, 1, 1, 2, 1, 1, 1, 1);
      repeat (3) next_cycle();
      ack_en = 1'b1;
      wait_done(50);
      next_cycle();
      chk("perf_stall_cycles", W'(o_stall_cycles), W'(3));
      chk("perf_q_empty", W'(exp_q.size()), W'(0));
`endif

      repeat (3) next_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
